// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid-buffer pipeline stage with flush, bubble zeroing and stall counter
module pipe_stage_buf #(
  parameter int CTRL_W = 14,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic push;
  logic pop;
  logic stall;

  // Handshake outputs depend only on the state register, never on the peer's inputs.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign stall = out_valid & ~out_ready;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;

    case (state_q)
      EMPTY: begin
        if (push) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end else if (push) begin
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
          state_d  = FULL;
        end else if (pop) begin
          // Zeroing the head control turns the idle output into a harmless bubble.
          m_ctrl_d = '0;
          state_d  = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      m_data_d = m_data_q;
      s_data_d = s_data_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - randomized self-checking bench for pipe_stage_buf against a queue model
module tb_pipe_stage_buf;

  localparam int CW = 14;
  localparam int DW = 69;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  // Reference: a FIFO of at most two entries plus the last head data seen.
  ent_t          mq[$];
  int            m_cnt;
  logic [DW-1:0] m_last;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic model_edge();
    bit   push;
    bit   pop;
    ent_t e;
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && out_ready;
    if (rst) begin
      mq.delete();
      m_cnt  = 0;
      m_last = '0;
    end else begin
      if ((mq.size() > 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.c = in_ctrl;
          e.d = in_data;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_last = mq[0].d;
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : '0);
    check("out_data", out_data, (mq.size() > 0) ? mq[0].d : m_last);
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic cycle(input bit r, input bit f, input bit iv, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input bit ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    mq.delete();
    m_cnt  = 0;
    m_last = '0;

    // Reset held with a live upstream entry
    cycle(1, 0, 1, 14'h3FFF, rnd_data(), 1);
    cycle(1, 0, 1, 14'h3FFF, rnd_data(), 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_data", out_data, 0);

    // Streaming 1..8 back to back
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, CW'(i), rnd_data(), 1);
      check("stream_ctrl", out_ctrl, i);
      check("stream_in_ready", in_ready, 1);
    end
    cycle(0, 0, 0, '0, rnd_data(), 1);
    check("stream_drained", out_valid, 0);

    // Skid: A in head, downstream stalls, B goes to skid
    cycle(0, 0, 1, 14'h00A1, rnd_data(), 1);
    cycle(0, 0, 1, 14'h00B2, rnd_data(), 0);
    check("skid_in_ready", in_ready, 0);
    check("skid_head_a", out_ctrl, 14'h00A1);
    cycle(0, 0, 1, 14'h0777, rnd_data(), 0);
    check("skid_hold_a", out_ctrl, 14'h00A1);
    cycle(0, 0, 0, '0, rnd_data(), 1);
    check("skid_head_b", out_ctrl, 14'h00B2);
    check("skid_release", in_ready, 1);
    cycle(0, 0, 0, '0, rnd_data(), 1);
    check("skid_empty", out_valid, 0);

    // Flush while full with a concurrent push of C
    cycle(0, 0, 1, 14'h0A0A, rnd_data(), 0);
    cycle(0, 0, 1, 14'h0B0B, rnd_data(), 0);
    cycle(0, 1, 1, 14'h2CCC, rnd_data(), 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    check("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, '0, rnd_data(), 1);
      check("flush_no_c", out_valid, 0);
    end

    // Bubble: regWrite/memtoReg entry must not linger after the pop
    cycle(0, 0, 1, 14'h0003, rnd_data(), 1);
    check("bubble_head", out_ctrl, 14'h0003);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, '0, rnd_data(), 1);
      check("bubble_ctrl", out_ctrl, 0);
    end

    // Stall counter saturation at 15
    cycle(1, 0, 0, '0, rnd_data(), 1);
    cycle(0, 0, 1, 14'h0055, rnd_data(), 1);
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 0, 0, '0, rnd_data(), 0);
      if (i == 14) check("cnt_at_14", stall_cnt, 14);
      if (i == 15) check("cnt_at_15", stall_cnt, 15);
    end
    check("cnt_sat", stall_cnt, 15);
    cycle(0, 1, 0, '0, rnd_data(), 0);
    check("cnt_after_flush", stall_cnt, 15);
    cycle(1, 0, 0, '0, rnd_data(), 0);
    check("cnt_after_rst", stall_cnt, 0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(149) == 0, $urandom_range(24) == 0, $urandom_range(3) != 0,
            CW'($urandom), rnd_data(), $urandom_range(2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
